// File: rtl/axi4_burst_addr_gen.sv
// AXI4 burst address / strobe generator.
// Accepts one address-channel command and emits one beat descriptor per
// transfer (address, byte strobe, index, last, error) for FIXED, INCR and
// WRAP bursts. Illegal commands are flagged but still produce len+1 beats.
module axi4_burst_addr_gen #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 16
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ID_WIDTH-1:0]      cmd_id,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [2:0]               cmd_size,
  input  logic [1:0]               cmd_burst,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic [ID_WIDTH-1:0]      beat_id,
  output logic [ADDRESS_WIDTH-1:0] beat_addr,
  output logic [DATA_WIDTH/8-1:0]  beat_strb,
  output logic [7:0]               beat_idx,
  output logic                     beat_last,
  output logic                     beat_err,
  output logic                     busy
);

  localparam int AW     = ADDRESS_WIDTH;
  localparam int NB     = DATA_WIDTH / 8;
  localparam int NB_LOG = $clog2(NB);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  // (bytes per beat) - 1 for a given awsize/arsize encoding.
  function automatic logic [AW-1:0] size_mask(input logic [2:0] size);
    return (AW'(1) << size) - AW'(1);
  endfunction

  // Lanes from the beat address up to the end of its size-aligned container.
  function automatic logic [NB-1:0] lane_strb(input logic [AW-1:0] addr,
                                              input logic [2:0]    size);
    logic [NB-1:0] strb;
    int            lo;
    int            hi;
    strb = '0;
    lo   = int'(addr & AW'(NB - 1));
    hi   = int'((addr & ~size_mask(size)) & AW'(NB - 1)) + (1 << size) - 1;
    for (int i = 0; i < NB; i++) strb[i] = (i >= lo) && (i <= hi);
    return strb;
  endfunction

  state_t              state_q;
  logic [ID_WIDTH-1:0] id_q;
  logic [AW-1:0]       addr_q;
  logic [AW-1:0]       lower_q;
  logic [AW-1:0]       wsize_q;
  logic [NB-1:0]       strb_q;
  logic [7:0]          idx_q;
  logic [7:0]          len_q;
  logic                last_q;
  logic                err_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;

  logic                beat_fire;
  logic                cmd_accept;
  logic [AW-1:0]       cmd_mask;
  logic [AW-1:0]       cmd_aligned;
  logic [AW-1:0]       cmd_wsize;
  logic [AW-1:0]       cmd_lower;
  logic [AW-1:0]       cmd_end;
  logic                cmd_err;
  logic [NB-1:0]       cmd_strb;

  logic [AW-1:0]       step;
  logic [AW-1:0]       wrap_sum;
  logic [AW-1:0]       addr_d;
  logic [NB-1:0]       strb_d;
  logic [7:0]          idx_d;
  logic                last_d;

  assign beat_valid = (state_q == S_BURST);
  assign busy       = (state_q == S_BURST);
  assign beat_fire  = beat_valid && beat_ready;
  // NOTE: cmd_ready depends combinationally on beat_ready so the next command
  // loads on the same edge the last beat retires (no bubble between bursts).
  assign cmd_ready  = !areset && (state_q == S_IDLE || (beat_fire && last_q));
  assign cmd_accept = cmd_valid && cmd_ready;

  assign beat_id   = id_q;
  assign beat_addr = addr_q;
  assign beat_strb = strb_q;
  assign beat_idx  = idx_q;
  assign beat_last = last_q;
  assign beat_err  = err_q;

  // Decode the offered command: per-burst constants, legality, beat-0 strobe.
  always_comb begin
    cmd_mask    = size_mask(cmd_size);
    cmd_aligned = cmd_addr & ~cmd_mask;
    cmd_wsize   = (AW'(cmd_len) + AW'(1)) << cmd_size;
    cmd_lower   = cmd_addr & ~(cmd_wsize - AW'(1));
    cmd_end     = cmd_aligned + cmd_wsize - AW'(1);
    cmd_err     = 1'b0;
    case (cmd_burst)
      BURST_FIXED: cmd_err = (cmd_len > 8'd15);
      BURST_INCR:  cmd_err = ((cmd_end >> 12) != (cmd_addr >> 12));
      BURST_WRAP:  cmd_err = !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}) ||
                             ((cmd_addr & cmd_mask) != '0);
      default:     cmd_err = 1'b1;
    endcase
    if (int'(cmd_size) > NB_LOG) cmd_err = 1'b1;
    cmd_strb = cmd_err ? '0 : lane_strb(cmd_addr, cmd_size);
  end

  // Address, strobe and index of the beat that follows the current one.
  always_comb begin
    step     = size_mask(size_q) + AW'(1);
    wrap_sum = addr_q + step;
    addr_d   = addr_q;
    case (burst_q)
      BURST_FIXED: addr_d = addr_q;
      BURST_WRAP:  addr_d = (wrap_sum == lower_q + wsize_q) ? lower_q : wrap_sum;
      default:     addr_d = (addr_q & ~size_mask(size_q)) + step;
    endcase
    strb_d = '0;
    if (!err_q) strb_d = (burst_q == BURST_FIXED) ? strb_q : lane_strb(addr_d, size_q);
    idx_d  = idx_q + 8'd1;
    last_d = (idx_d == len_q);
  end

  // Burst FSM: load beat 0 on accept, advance on each beat handshake.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      lower_q <= '0;
      wsize_q <= '0;
      strb_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      burst_q <= '0;
    end else if (cmd_accept) begin
      // NOTE: non-blocking assignments here so every register sees pre-edge
      // values; accept takes priority because it only coincides with the
      // retirement of the previous burst's last beat.
      state_q <= S_BURST;
      id_q    <= cmd_id;
      addr_q  <= cmd_addr;
      lower_q <= cmd_lower;
      wsize_q <= cmd_wsize;
      strb_q  <= cmd_strb;
      idx_q   <= 8'd0;
      len_q   <= cmd_len;
      last_q  <= (cmd_len == 8'd0);
      err_q   <= cmd_err;
      size_q  <= cmd_size;
      burst_q <= cmd_burst;
    end else if (beat_fire) begin
      if (last_q) begin
        state_q <= S_IDLE;
      end else begin
        addr_q <= addr_d;
        strb_q <= strb_d;
        idx_q  <= idx_d;
        last_q <= last_d;
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Self-checking bench for axi4_burst_addr_gen (32-bit address, 32-bit data).
module tb_axi4_burst_addr_gen;

  localparam int NB = 4;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_id = '0;
  logic [31:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [2:0]  cmd_size = '0;
  logic [1:0]  cmd_burst = '0;
  logic        beat_valid;
  logic        beat_ready = 1'b0;
  logic [15:0] beat_id;
  logic [31:0] beat_addr;
  logic [3:0]  beat_strb;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        beat_err;
  logic        busy;

  axi4_burst_addr_gen #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .ID_WIDTH     (16)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_size  (cmd_size),
    .cmd_burst (cmd_burst),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_id   (beat_id),
    .beat_addr (beat_addr),
    .beat_strb (beat_strb),
    .beat_idx  (beat_idx),
    .beat_last (beat_last),
    .beat_err  (beat_err),
    .busy      (busy)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0] id;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [7:0]  idx;
    logic        last;
    logic        err;
  } beat_t;

  typedef struct {
    logic [1:0]  burst;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    int          nbeats;
    logic        err;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] an;
    logic [3:0]  sn;
  } vec_t;

  int    total = 0;
  int    bad = 0;
  beat_t got[$];
  beat_t exp_q[$];
  vec_t  tbl[8];
  bit    rand_ready = 1'b0;

  // Back-to-back / backpressure script: per-cycle ready and expectations.
  localparam logic        B2B_RDY   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic        B2B_VALID [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic        B2B_CRDY  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam logic [31:0] B2B_ADDR  [6] = '{32'h2000, 32'h2004, 32'h2004, 32'h2004, 32'h3000, 32'h0};
  localparam logic [15:0] B2B_ID    [6] = '{16'hA, 16'hA, 16'hA, 16'hA, 16'hB, 16'h0};
  localparam logic [7:0]  B2B_IDX   [6] = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: list every beat of a command straight from the burst rules.
  task automatic model_push(input logic [15:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
    int          bytes;
    int          nbeats;
    int          lo;
    int          hi;
    logic [31:0] bmask;
    logic [31:0] aligned;
    logic [31:0] wsize;
    logic [31:0] lower;
    logic [31:0] last_byte;
    logic [31:0] a;
    logic [3:0]  s;
    logic        err;
    bytes     = 1 << size;
    nbeats    = int'(len) + 1;
    bmask     = 32'(bytes - 1);
    aligned   = addr & ~bmask;
    wsize     = 32'(bytes * nbeats);
    lower     = addr & ~(wsize - 32'd1);
    last_byte = aligned + 32'(nbeats * bytes) - 32'd1;
    err = (burst == 2'b11) || (bytes > NB) ||
          (burst == 2'b00 && len > 8'd15) ||
          (burst == 2'b10 && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (addr & bmask) != 32'd0)) ||
          (burst == 2'b01 && last_byte[31:12] != addr[31:12]);
    a = addr;
    for (int n = 0; n < nbeats; n++) begin
      if (n > 0) begin
        if (burst == 2'b00) a = addr;
        else if (burst == 2'b10) begin
          a = a + 32'(bytes);
          if (a == lower + wsize) a = lower;
        end else a = aligned + 32'(n * bytes);
      end
      lo = int'(a % 32'd4);
      hi = int'((a & ~bmask) % 32'd4) + bytes - 1;
      s  = '0;
      for (int i = 0; i < 4; i++) if (i >= lo && i <= hi) s[i] = 1'b1;
      if (err) s = '0;
      exp_q.push_back('{id, a, s, 8'(n), (n == nbeats - 1), err});
    end
  endtask

  // Offer a command until accepted; afterwards scramble cmd_* (must be ignored).
  task automatic send_cmd(input logic [15:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst);
    int cyc;
    bit done;
    cyc = 0;
    done = 1'b0;
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
    while (!done && cyc < 5000) begin
      @(negedge aclk);
      done = cmd_ready;
      @(posedge aclk);
      #1;
      cyc++;
    end
    cmd_valid = 1'b0;
    cmd_id    = 16'($urandom);
    cmd_addr  = $urandom;
    cmd_len   = 8'($urandom);
    cmd_size  = 3'($urandom);
    cmd_burst = 2'($urandom);
    if (!done) check("cmd_accept_timeout", 64'(done), 64'd1);
  endtask

  task automatic wait_got(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (got.size() < n && cyc < budget) begin
      @(posedge aclk);
      #1;
      cyc++;
    end
    if (got.size() < n) check("beat_wait_timeout", 64'(got.size()), 64'(n));
  endtask

  // Collect handshaken beats; check that stalled beats hold all outputs.
  beat_t snap;
  bit    snap_ok = 1'b0;
  always @(negedge aclk) begin
    if (!areset && beat_valid && beat_ready)
      got.push_back('{beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_err});
    if (snap_ok && !areset) begin
      check("stall_valid", 64'(beat_valid), 64'd1);
      check("stall_addr", 64'(beat_addr), 64'(snap.addr));
      check("stall_fields", {36'd0, beat_id, beat_strb, beat_idx, beat_last, beat_err},
            {36'd0, snap.id, snap.strb, snap.idx, snap.last, snap.err});
    end
    snap_ok = !areset && beat_valid && !beat_ready;
    snap    = '{beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_err};
  end

  // Random backpressure; writes land after the main sequence's own updates.
  always @(posedge aclk) begin
    #2;
    if (rand_ready) beat_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            burst  addr          size  len    n   err   a0            s0       an            sn
    tbl[0] = '{2'b01, 32'h0000_1002, 3'd2, 8'd3,  4,  1'b0, 32'h0000_1002, 4'b1100, 32'h0000_100C, 4'b1111};
    tbl[1] = '{2'b10, 32'h0000_1034, 3'd2, 8'd3,  4,  1'b0, 32'h0000_1034, 4'b1111, 32'h0000_1030, 4'b1111};
    tbl[2] = '{2'b00, 32'h0000_0201, 3'd0, 8'd2,  3,  1'b0, 32'h0000_0201, 4'b0010, 32'h0000_0201, 4'b0010};
    tbl[3] = '{2'b01, 32'h0000_0FF8, 3'd2, 8'd3,  4,  1'b1, 32'h0000_0FF8, 4'b0000, 32'h0000_1004, 4'b0000};
    tbl[4] = '{2'b11, 32'h0000_0040, 3'd2, 8'd0,  1,  1'b1, 32'h0000_0040, 4'b0000, 32'h0000_0040, 4'b0000};
    tbl[5] = '{2'b10, 32'h0000_1030, 3'd2, 8'd2,  3,  1'b1, 32'h0000_1030, 4'b0000, 32'h0000_1038, 4'b0000};
    tbl[6] = '{2'b01, 32'h0000_0100, 3'd3, 8'd1,  2,  1'b1, 32'h0000_0100, 4'b0000, 32'h0000_0108, 4'b0000};
    tbl[7] = '{2'b00, 32'h0000_0010, 3'd2, 8'd16, 17, 1'b1, 32'h0000_0010, 4'b0000, 32'h0000_0010, 4'b0000};

    // ---- reset state ----
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_beat_valid", 64'(beat_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_beat_id", 64'(beat_id), 64'd0);
    check("rst_beat_addr", 64'(beat_addr), 64'd0);
    check("rst_beat_strb", 64'(beat_strb), 64'd0);
    check("rst_beat_idx", 64'(beat_idx), 64'd0);
    check("rst_beat_last", 64'(beat_last), 64'd0);
    check("rst_beat_err", 64'(beat_err), 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge aclk);
    #1;
    beat_ready = 1'b1;

    // ---- table-driven directed commands ----
    for (int v = 0; v < 8; v++) begin
      got.delete();
      exp_q.delete();
      model_push(16'(16'h100 + v), tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst);
      send_cmd(16'(16'h100 + v), tbl[v].addr, tbl[v].len, tbl[v].size, tbl[v].burst);
      wait_got(tbl[v].nbeats, 500);
      repeat (4) begin
        @(posedge aclk);
        #1;
      end
      check($sformatf("v%0d_nbeats", v), 64'(got.size()), 64'(tbl[v].nbeats));
      if (got.size() == tbl[v].nbeats) begin
        check($sformatf("v%0d_addr0", v), 64'(got[0].addr), 64'(tbl[v].a0));
        check($sformatf("v%0d_strb0", v), 64'(got[0].strb), 64'(tbl[v].s0));
        check($sformatf("v%0d_addrN", v), 64'(got[tbl[v].nbeats-1].addr), 64'(tbl[v].an));
        check($sformatf("v%0d_strbN", v), 64'(got[tbl[v].nbeats-1].strb), 64'(tbl[v].sn));
        for (int i = 0; i < tbl[v].nbeats; i++) begin
          check($sformatf("v%0d_b%0d_err", v, i), 64'(got[i].err), 64'(tbl[v].err));
          check($sformatf("v%0d_b%0d_idx_last", v, i), {55'd0, got[i].idx, got[i].last},
                {55'd0, 8'(i), (i == tbl[v].nbeats - 1)});
          check($sformatf("v%0d_b%0d_model", v, i), {28'd0, got[i].strb, got[i].addr},
                {28'd0, exp_q[i].strb, exp_q[i].addr});
        end
      end
    end

    // ---- back-to-back with backpressure ----
    got.delete();
    cmd_valid = 1'b1;
    cmd_id    = 16'hA;
    cmd_addr  = 32'h2000;
    cmd_len   = 8'd1;
    cmd_size  = 3'd2;
    cmd_burst = 2'b01;
    @(negedge aclk);
    check("b2b_idle_ready", 64'(cmd_ready), 64'd1);
    @(posedge aclk);
    #1;
    cmd_id    = 16'hB;
    cmd_addr  = 32'h3000;
    cmd_len   = 8'd0;
    for (int i = 0; i < 6; i++) begin
      beat_ready = B2B_RDY[i];
      @(negedge aclk);
      check($sformatf("b2b_c%0d_valid", i), 64'(beat_valid), 64'(B2B_VALID[i]));
      check($sformatf("b2b_c%0d_cmd_ready", i), 64'(cmd_ready), 64'(B2B_CRDY[i]));
      if (B2B_VALID[i]) begin
        check($sformatf("b2b_c%0d_addr", i), 64'(beat_addr), 64'(B2B_ADDR[i]));
        check($sformatf("b2b_c%0d_id_idx", i), {40'd0, beat_id, beat_idx},
              {40'd0, B2B_ID[i], B2B_IDX[i]});
      end
      @(posedge aclk);
      #1;
      if (i == 3) cmd_valid = 1'b0;
    end
    check("b2b_nbeats", 64'(got.size()), 64'd3);
    beat_ready = 1'b1;

    // ---- reset in the middle of a burst ----
    got.delete();
    send_cmd(16'h77, 32'h4000, 8'd7, 3'd2, 2'b01);
    repeat (3) begin
      @(posedge aclk);
      #1;
    end
    areset = 1'b1;
    @(negedge aclk);
    check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("midrst_beats_before", 64'(got.size()), 64'd3);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("midrst_valid", 64'(beat_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(posedge aclk);
    #1;
    got.delete();
    send_cmd(16'h78, 32'h5008, 8'd1, 3'd2, 2'b01);
    wait_got(2, 100);
    repeat (4) begin
      @(posedge aclk);
      #1;
    end
    check("midrst_new_nbeats", 64'(got.size()), 64'd2);
    if (got.size() == 2) begin
      check("midrst_new_b0", {24'd0, got[0].addr, got[0].idx}, {24'd0, 32'h5008, 8'd0});
      check("midrst_new_b1", {23'd0, got[1].addr, got[1].idx, got[1].last},
            {23'd0, 32'h500C, 8'd1, 1'b1});
    end

    // ---- randomized commands with random backpressure vs. reference model ----
    got.delete();
    exp_q.delete();
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic [15:0] id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      id    = 16'($urandom);
      burst = 2'($urandom_range(0, 3));
      size  = 3'($urandom_range(0, 3));
      addr  = $urandom;
      if ($urandom_range(0, 2) == 0) addr = {addr[31:12], 4'hF, addr[7:0]};
      len = 8'($urandom_range(0, 12));
      if (burst == 2'b10 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0:       len = 8'd1;
          1:       len = 8'd3;
          2:       len = 8'd7;
          default: len = 8'd15;
        endcase
        addr = addr & ~((32'd1 << size) - 32'd1);
      end
      if (burst == 2'b00 && $urandom_range(0, 4) == 0) len = 8'($urandom_range(16, 20));
      if (burst == 2'b11) len = 8'd0;
      model_push(id, addr, len, size, burst);
      send_cmd(id, addr, len, size, burst);
    end
    wait_got(exp_q.size(), 20000);
    rand_ready = 1'b0;
    @(posedge aclk);
    #3;
    beat_ready = 1'b1;
    repeat (4) begin
      @(posedge aclk);
      #1;
    end
    check("rand_nbeats", 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check($sformatf("rand_b%0d_addr", i), 64'(got[i].addr), 64'(exp_q[i].addr));
      check($sformatf("rand_b%0d_strb_err", i), {59'd0, got[i].strb, got[i].err},
            {59'd0, exp_q[i].strb, exp_q[i].err});
      check($sformatf("rand_b%0d_id_idx_last", i), {39'd0, got[i].id, got[i].idx, got[i].last},
            {39'd0, exp_q[i].id, exp_q[i].idx, exp_q[i].last});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
